axi_ar_arbiter: RTL and testbench
=================================

Name: axi_ar_arbiter

Overview:
- N:1 round-robin arbiter for the AXI read-address (AR) channel.
- Sits directly upstream of axi_interconnect and drives one of its master AR ports, so several requestors can share that port.
- The output is a single-entry register stage: ARVALID/ARADDR/ARPROT on the downstream side come straight from flops.
- Sustains one transfer per cycle when the downstream side is always ready.

Parameters:
NUM_MASTERS, 4, number of upstream requestors (>=1)
ADDR_WIDTH, 32, AR address width
IDX_WIDTH, 2, grant index width; must satisfy 2**IDX_WIDTH >= NUM_MASTERS (use 1 when NUM_MASTERS=1)

Ports:
ACLK  in  1  single clock; all logic rising-edge
ARESETN  in  1  synchronous, active-low reset
S_AXI_ARADDR  in  NUM_MASTERS*ADDR_WIDTH  upstream addresses, requestor i at [i*ADDR_WIDTH +: ADDR_WIDTH]
S_AXI_ARPROT  in  NUM_MASTERS*3  upstream prot, requestor i at [i*3 +: 3]
S_AXI_ARVALID  in  NUM_MASTERS  upstream valids
S_AXI_ARREADY  out  NUM_MASTERS  upstream readys, at most one bit high (one-hot or zero)
M_AXI_ARADDR  out  ADDR_WIDTH  registered address to interconnect
M_AXI_ARPROT  out  3  registered prot
M_AXI_ARVALID  out  1  registered valid
M_AXI_ARREADY  in  1  downstream ready
M_AXI_ARGRANT  out  IDX_WIDTH  index of the requestor whose beat is held in the output register

Behaviour:
- Reset (sampled at a rising edge with ARESETN=0):
  - M_AXI_ARVALID=0, M_AXI_ARADDR=0, M_AXI_ARPROT=0, M_AXI_ARGRANT=0.
  - Round-robin pointer ptr=0, state=EMPTY.
  - S_AXI_ARREADY=0 while ARESETN=0.
- States:
  - EMPTY: output register holds nothing.
  - FULL: output register holds a beat and M_AXI_ARVALID=1.
- Register free condition: free = (state==EMPTY) | (M_AXI_ARREADY & M_AXI_ARVALID).
- Winner selection (combinational): first i with S_AXI_ARVALID[i]=1, scanning ptr, ptr+1, ... modulo NUM_MASTERS.
- Upstream ready: S_AXI_ARREADY[winner]=1 only when free=1 and some valid is set; all other bits are 0.
- Accept (free & |S_AXI_ARVALID) at the clock edge:
  - load M_AXI_ARADDR/ARPROT from the winner's slice;
  - M_AXI_ARGRANT<=winner, M_AXI_ARVALID<=1, state->FULL;
  - ptr<=(winner+1) mod NUM_MASTERS, wrapping NUM_MASTERS-1 -> 0.
- Downstream handshake with no new accept: M_AXI_ARVALID<=0, state->EMPTY. ARADDR, ARPROT and ARGRANT keep their last values.
- Simultaneous downstream handshake and upstream accept: the register is reloaded in the same cycle and ARVALID stays 1. This gives back-to-back beats with no bubble.
- Stall (FULL and M_AXI_ARREADY=0): output register and ptr are frozen, and all S_AXI_ARREADY bits are 0. ARVALID is never dropped before the handshake, as AXI requires.
- Latency: an upstream handshake at edge k produces M_AXI_ARVALID=1 after edge k (one cycle).
- Combinational path S_AXI_ARREADY <- M_AXI_ARREADY is intended. There is no path from M_AXI_ARREADY to M_AXI_ARVALID/ADDR/PROT.
- ptr only advances on an accept; idle cycles leave it unchanged.
- NUM_MASTERS=1: ptr stays 0 and the block behaves as a plain AR register slice.
- Reset mid-operation (ARESETN=0 while FULL): the held beat is discarded and all state returns to the reset values on that edge.
- Protocol violations (upstream drops ARVALID before ready) are not detected. The arbiter simply re-selects on the next cycle.

Decomposition:
- Shared package axi_pkg holds:
  - AXI_PROT_WIDTH=3;
  - the state encoding (EMPTY=1'b0, FULL=1'b1);
  - a helper function for the modulo-N increment.
- One sub-module is natural: rr_arbiter. It is purely combinational, takes req vector + ptr, and returns a one-hot grant, a grant index, and an any-request flag. It is reusable for future AW-channel and interconnect arbitration.

Test Plan:
- Reset with S_AXI_ARVALID=4'b1111 held → all outputs 0 and S_AXI_ARREADY=0 during reset. Then:
  - first grant is requestor 0, with M_AXI_ARGRANT=0 and M_AXI_ARADDR=addr0 one cycle later;
  - with M_AXI_ARREADY=1 continuously, grants follow 0,1,2,3,0 on consecutive cycles with ARVALID never dropping.
- Only requestor 2 valid (addr 0x8000_1000, prot 3'b010), M_AXI_ARREADY=1 → S_AXI_ARREADY=4'b0100 in the same cycle; next cycle M_AXI_ARADDR=0x8000_1000, ARPROT=3'b010, ARGRANT=2; resulting ptr=3.
- ptr=3 with requestors 3 and 0 valid → 3 wins, then ptr wraps to 0 and requestor 0 wins next.
- Hold M_AXI_ARREADY=0 for 5 cycles while FULL and requestors 1,3 valid → outputs stable, S_AXI_ARREADY=0 throughout; on ready=1, handshake and reload in the same cycle.
- Assert ARESETN=0 for one edge while FULL with ARVALID=1 → next cycle ARVALID=0, ptr=0, state EMPTY; the discarded beat never appears downstream.
- NUM_MASTERS=1 build: 10 beats with random M_AXI_ARREADY → addresses are delivered in order with no loss or duplication, and ARGRANT is always 0.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI definitions: channel field widths, the register-slice state
// encoding and small index helpers used by the arbiters.
package axi_pkg;

    localparam int unsigned AXI_PROT_WIDTH = 3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slice_state_e;

    // Increment modulo n, wrapping n-1 back to 0.
    function automatic int unsigned mod_inc(input int unsigned val, input int unsigned n);
        if (val + 1 >= n) begin
            return '0;
        end
        return val + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: picks the first asserted request
// scanning from ptr upward, modulo N.
module rr_arbiter #(
    parameter int unsigned N         = 4,
    parameter int unsigned IDX_WIDTH = 2
) (
    input  logic [N-1:0]         req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [IDX_WIDTH-1:0] grant_idx,
    output logic                 any_req
);

    int unsigned idx;
    logic        found;

    assign any_req = |req;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = 32'(ptr) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDX_WIDTH'(idx);
            end
        end
    end

endmodule

// File: rtl/axi_ar_arbiter.sv
// N:1 round-robin arbiter for the AXI AR channel with a single-entry
// registered output stage; back-to-back beats when downstream is ready.
module axi_ar_arbiter
    import axi_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned IDX_WIDTH   = 2
) (
    input  logic                                ACLK,
    input  logic                                ARESETN,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [NUM_MASTERS*AXI_PROT_WIDTH-1:0] S_AXI_ARPROT,
    input  logic [NUM_MASTERS-1:0]              S_AXI_ARVALID,
    output logic [NUM_MASTERS-1:0]              S_AXI_ARREADY,
    output logic [ADDR_WIDTH-1:0]               M_AXI_ARADDR,
    output logic [AXI_PROT_WIDTH-1:0]           M_AXI_ARPROT,
    output logic                                M_AXI_ARVALID,
    input  logic                                M_AXI_ARREADY,
    output logic [IDX_WIDTH-1:0]                M_AXI_ARGRANT
);

    slice_state_e              state_q, state_d;
    logic [IDX_WIDTH-1:0]      ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [AXI_PROT_WIDTH-1:0] prot_q, prot_d;
    logic [IDX_WIDTH-1:0]      gidx_q, gidx_d;

    logic [NUM_MASTERS-1:0]    grant;
    logic [IDX_WIDTH-1:0]      winner;
    logic                      any_req;
    logic                      free;
    logic                      accept;
    logic [ADDR_WIDTH-1:0]     sel_addr;
    logic [AXI_PROT_WIDTH-1:0] sel_prot;

    rr_arbiter #(
        .N         (NUM_MASTERS),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_rr (
        .req       (S_AXI_ARVALID),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (winner),
        .any_req   (any_req)
    );

    assign M_AXI_ARVALID = (state_q == FULL);
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = prot_q;
    assign M_AXI_ARGRANT = gidx_q;

    assign free          = (state_q == EMPTY) | (M_AXI_ARREADY & M_AXI_ARVALID);
    assign accept        = free & any_req;
    assign S_AXI_ARREADY = (accept && ARESETN) ? grant : '0;

    // One-hot AND-OR mux keeps the slice selection free of index arithmetic.
    always_comb begin
        sel_addr = '0;
        sel_prot = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (grant[i]) begin
                sel_addr = sel_addr | S_AXI_ARADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_prot = sel_prot | S_AXI_ARPROT[i*AXI_PROT_WIDTH +: AXI_PROT_WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        prot_d  = prot_q;
        gidx_d  = gidx_q;
        if (accept) begin
            state_d = FULL;
            addr_d  = sel_addr;
            prot_d  = sel_prot;
            gidx_d  = winner;
            ptr_d   = IDX_WIDTH'(mod_inc(32'(winner), NUM_MASTERS));
        end else if (state_q == FULL && M_AXI_ARREADY) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            addr_q  <= '0;
            prot_q  <= '0;
            gidx_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            prot_q  <= prot_d;
            gidx_q  <= gidx_d;
        end
    end

endmodule

// File: tb/tb_axi_ar_arbiter.sv
// Directed bench for axi_ar_arbiter: a 4-requestor instance for arbitration
// and stall/reset cases, and a 1-requestor instance used as a register slice.
module tb_axi_ar_arbiter;

    logic        clk;
    logic        rstn;

    logic [127:0] s_addr;
    logic [11:0]  s_prot;
    logic [3:0]   s_valid;
    logic [3:0]   s_ready;
    logic [31:0]  m_addr;
    logic [2:0]   m_prot;
    logic         m_valid;
    logic         m_ready;
    logic [1:0]   m_grant;

    logic [31:0]  s1_addr;
    logic [2:0]   s1_prot;
    logic [0:0]   s1_valid;
    logic [0:0]   s1_ready;
    logic [31:0]  m1_addr;
    logic [2:0]   m1_prot;
    logic         m1_valid;
    logic         m1_ready;
    logic [0:0]   m1_grant;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    axi_ar_arbiter #(
        .NUM_MASTERS (4),
        .ADDR_WIDTH  (32),
        .IDX_WIDTH   (2)
    ) dut (
        .ACLK          (clk),
        .ARESETN       (rstn),
        .S_AXI_ARADDR  (s_addr),
        .S_AXI_ARPROT  (s_prot),
        .S_AXI_ARVALID (s_valid),
        .S_AXI_ARREADY (s_ready),
        .M_AXI_ARADDR  (m_addr),
        .M_AXI_ARPROT  (m_prot),
        .M_AXI_ARVALID (m_valid),
        .M_AXI_ARREADY (m_ready),
        .M_AXI_ARGRANT (m_grant)
    );

    axi_ar_arbiter #(
        .NUM_MASTERS (1),
        .ADDR_WIDTH  (32),
        .IDX_WIDTH   (1)
    ) dut1 (
        .ACLK          (clk),
        .ARESETN       (rstn),
        .S_AXI_ARADDR  (s1_addr),
        .S_AXI_ARPROT  (s1_prot),
        .S_AXI_ARVALID (s1_valid),
        .S_AXI_ARREADY (s1_ready),
        .M_AXI_ARADDR  (m1_addr),
        .M_AXI_ARPROT  (m1_prot),
        .M_AXI_ARVALID (m1_valid),
        .M_AXI_ARREADY (m1_ready),
        .M_AXI_ARGRANT (m1_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] addr_of(input int unsigned i);
        return 32'hA000_0000 + 32'(i) * 32'h10;
    endfunction

    int unsigned exp_seq [5] = '{0, 1, 2, 3, 0};
    logic [31:0] src [10];
    int unsigned in_idx;
    int unsigned out_idx;
    logic        up_hs;
    logic        dn_hs;

    initial begin
        rstn     = 1'b0;
        m_ready  = 1'b1;
        s_valid  = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            s_addr[i*32 +: 32] = addr_of(i);
            s_prot[i*3 +: 3]   = 3'(i);
        end
        s1_addr  = '0;
        s1_prot  = '0;
        s1_valid = '0;
        m1_ready = 1'b0;

        // Reset with all requestors valid
        tick();
        tick();
        @(negedge clk);
        check("rst_s_ready", s_ready, 4'b0000);
        check("rst_valid", m_valid, 1'b0);
        check("rst_addr", m_addr, 32'h0);
        check("rst_prot", m_prot, 3'h0);
        check("rst_grant", m_grant, 2'd0);
        tick();
        rstn = 1'b1;
        @(negedge clk);
        check("first_s_ready", s_ready, 4'b0001);

        // Streaming round robin with downstream always ready
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rr_valid", m_valid, 1'b1);
            check("rr_grant", m_grant, 2'(exp_seq[k]));
            check("rr_addr", m_addr, addr_of(exp_seq[k]));
        end
        s_valid = 4'b0000;
        tick();
        check("drain_valid", m_valid, 1'b0);
        check("drain_grant_kept", m_grant, 2'd0);
        check("drain_addr_kept", m_addr, addr_of(0));

        // Lone requestor 2, ptr is 1
        s_addr[2*32 +: 32] = 32'h8000_1000;
        s_prot[2*3 +: 3]   = 3'b010;
        s_valid            = 4'b0100;
        @(negedge clk);
        check("r2_s_ready", s_ready, 4'b0100);
        tick();
        check("r2_addr", m_addr, 32'h8000_1000);
        check("r2_prot", m_prot, 3'b010);
        check("r2_grant", m_grant, 2'd2);

        // ptr=3, requestors 3 and 0: 3 wins, then wrap to 0
        s_valid = 4'b1001;
        @(negedge clk);
        check("wrap_s_ready3", s_ready, 4'b1000);
        tick();
        check("wrap_grant3", m_grant, 2'd3);
        check("wrap_addr3", m_addr, addr_of(3));
        @(negedge clk);
        check("wrap_s_ready0", s_ready, 4'b0001);
        tick();
        check("wrap_grant0", m_grant, 2'd0);
        check("wrap_valid", m_valid, 1'b1);

        // Stall while FULL with requestors 1 and 3 waiting
        s_valid = 4'b1010;
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_s_ready", s_ready, 4'b0000);
            tick();
            check("stall_valid", m_valid, 1'b1);
            check("stall_grant", m_grant, 2'd0);
            check("stall_addr", m_addr, addr_of(0));
        end
        m_ready = 1'b1;
        @(negedge clk);
        check("unstall_s_ready", s_ready, 4'b0010);
        tick();
        check("unstall_valid", m_valid, 1'b1);
        check("unstall_grant", m_grant, 2'd1);
        check("unstall_addr", m_addr, addr_of(1));

        // Reset while FULL discards the held beat
        s_valid = 4'b0000;
        m_ready = 1'b0;
        rstn    = 1'b0;
        tick();
        check("mid_rst_valid", m_valid, 1'b0);
        check("mid_rst_grant", m_grant, 2'd0);
        check("mid_rst_addr", m_addr, 32'h0);
        rstn    = 1'b1;
        s_valid = 4'b1111;
        m_ready = 1'b1;
        @(negedge clk);
        check("post_rst_ptr0", s_ready, 4'b0001);
        tick();
        check("post_rst_grant", m_grant, 2'd0);
        check("post_rst_addr", m_addr, addr_of(0));
        s_valid = 4'b0000;
        tick();
        check("post_rst_idle", m_valid, 1'b0);

        // Single-requestor build: ordered delivery under random backpressure
        for (int i = 0; i < 10; i++) begin
            src[i] = 32'h0000_1000 + 32'(i) * 32'h44;
        end
        in_idx   = 0;
        out_idx  = 0;
        s1_valid = 1'b1;
        s1_addr  = src[0];
        m1_ready = 1'($urandom_range(0, 1));
        for (int cyc = 0; cyc < 200 && out_idx < 10; cyc++) begin
            @(negedge clk);
            up_hs = s1_valid[0] & s1_ready[0];
            dn_hs = m1_valid & m1_ready;
            if (dn_hs) begin
                check("slice_addr", m1_addr, src[out_idx]);
                check("slice_grant", m1_grant, 1'b0);
            end
            tick();
            if (up_hs) in_idx++;
            if (dn_hs) out_idx++;
            s1_valid = (in_idx < 10) ? 1'b1 : 1'b0;
            s1_addr  = (in_idx < 10) ? src[in_idx] : 32'h0;
            m1_ready = 1'($urandom_range(0, 1));
        end
        check("slice_count", 64'(out_idx), 64'd10);
        m1_ready = 1'b1;
        tick();
        tick();
        check("slice_no_dup", m1_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
